// File: rtl/serial_eq_pkg.sv
// serial_eq_pkg: shared state type, default frame length and count-width helper for serial_eq_checker.
package serial_eq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int FRAME_LEN_DEF = 8;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/serial_eq_checker_xnor_gate.sv
// xnor_gate: single-bit equality primitive.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a ^ b);
endmodule

// File: rtl/serial_eq_checker.sv
// serial_eq_checker: bit-serial frame equality checker with start/abort handshake and registered verdict.
// SERIAL_EQ_FIRST_IDX_EN builds the first-mismatch index latch; otherwise first_mis_* are tied to 0.
module serial_eq_checker
  import serial_eq_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_mis_idx,
  output logic             first_mis_valid
);
  state_t state, next;
  logic eq_bit, enter, take, last;
  logic [CNT_W-1:0] cnt, idx, cnt_nx;
  xnor_gate u_xnor (.a(a_bit), .b(b_bit), .y(eq_bit));
  assign enter  = state == IDLE && start && !abort;
  assign take   = state == RUN && bit_valid && !abort;
  assign last   = idx == CNT_W'(FRAME_LEN - 1);
  assign cnt_nx = cnt + CNT_W'(!eq_bit);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state == DONE ? IDLE : abort ? IDLE : state == IDLE ? (start ? RUN : IDLE) : (take && last ? DONE : RUN);
  end
  // Results only move on the completing edge, so aborted frames leave them untouched.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      equal        <= 1'b0;
      mismatch_cnt <= '0;
    end else if (enter) begin
      cnt <= '0;
      idx <= '0;
    end else if (take) begin
      cnt <= cnt_nx;
      idx <= last ? '0 : idx + CNT_W'(1);
      if (last) begin
        equal        <= cnt_nx == '0;
        mismatch_cnt <= cnt_nx;
      end
    end
`ifdef SERIAL_EQ_FIRST_IDX_EN
  logic [CNT_W-1:0] first_idx;
  logic             first_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      first_idx       <= '0;
      first_valid     <= 1'b0;
      first_mis_idx   <= '0;
      first_mis_valid <= 1'b0;
    end else if (enter) begin
      first_idx   <= '0;
      first_valid <= 1'b0;
    end else if (take) begin
      if (!eq_bit && !first_valid) begin
        first_idx   <= idx;
        first_valid <= 1'b1;
      end
      if (last) begin
        first_mis_idx   <= first_valid ? first_idx : idx;
        first_mis_valid <= first_valid || !eq_bit;
      end
    end
`else
  assign first_mis_idx   = '0;
  assign first_mis_valid = 1'b0;
`endif
endmodule

// File: tb/tb_serial_eq_checker.sv
// tb_serial_eq_checker: table-driven, hand-written and randomized frame checks against a frame-level model.
module tb_serial_eq_checker;
  typedef struct {
    logic       eq;
    logic [3:0] cnt;
    logic [3:0] fidx;
    logic       fval;
  } res_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         gap;
    res_t       e;
  } vec_t;
`ifdef SERIAL_EQ_FIRST_IDX_EN
  localparam bit FI_EN = 1'b1;
`else
  localparam bit FI_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, abort = 0, bit_valid = 0, a_bit = 0, b_bit = 0;
  logic busy, done, equal, first_mis_valid;
  logic [3:0] mismatch_cnt, first_mis_idx;
  int n_cmp = 0, n_bad = 0;
  res_t cur, m;
  vec_t vec[8];
  serial_eq_checker #(.FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done), .equal(equal),
    .mismatch_cnt(mismatch_cnt), .first_mis_idx(first_mis_idx), .first_mis_valid(first_mis_valid)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_res(input string n, input res_t e);
    chk({n, "_equal"}, equal, e.eq);
    chk({n, "_cnt"}, mismatch_cnt, e.cnt);
    chk({n, "_fidx"}, first_mis_idx, FI_EN ? e.fidx : 4'd0);
    chk({n, "_fval"}, first_mis_valid, FI_EN ? e.fval : 1'b0);
  endtask

  // Frame-level reference: count and locate differing bit positions directly.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    logic [7:0] d;
    d = a ^ b;
    r.cnt  = 4'($countones(d));
    r.eq   = d == 8'd0;
    r.fval = d != 8'd0;
    r.fidx = 4'd0;
    for (int i = 7; i >= 0; i--) if (d[i]) r.fidx = 4'(i);
    return r;
  endfunction

  // abort_at < 0: full frame, e = new results; otherwise abort on that index, e = retained results.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input int gap, input bit hold,
                       input int abort_at, input res_t e);
    start = 1; abort = 0; bit_valid = 0;
    step();
    chk("busy_on", busy, 1);
    start = hold;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        bit_valid = 0;
        step();
        chk("gap_busy", busy, 1);
        chk("gap_done", done, 0);
      end
      bit_valid = 1; a_bit = a[i]; b_bit = b[i]; abort = (i == abort_at);
      step();
      if (abort) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        break;
      end
      if (i == 7) chk("fin_done", done, 1);
      else chk("mid_done", done, 0);
    end
    start = 0; abort = 0; bit_valid = 0;
    chk_res("res", e);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    vec[0] = '{8'hA5, 8'hA5, 0, '{1'b1, 4'd0, 4'd0, 1'b0}};
    vec[1] = '{8'hFF, 8'h00, 0, '{1'b0, 4'd8, 4'd0, 1'b1}};
    vec[2] = '{8'h00, 8'hA0, 3, '{1'b0, 4'd2, 4'd5, 1'b1}};
    vec[3] = '{8'h0F, 8'h0E, 1, '{1'b0, 4'd1, 4'd0, 1'b1}};
    vec[4] = '{8'h80, 8'h00, 0, '{1'b0, 4'd1, 4'd7, 1'b1}};
    vec[5] = '{8'h55, 8'hAA, 1, '{1'b0, 4'd8, 4'd0, 1'b1}};
    vec[6] = '{8'h3C, 8'h3C, 2, '{1'b1, 4'd0, 4'd0, 1'b0}};
    vec[7] = '{8'h10, 8'h00, 0, '{1'b0, 4'd1, 4'd4, 1'b1}};
    cur = '{1'b0, 4'd0, 4'd0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_res("rst", cur);
    rst = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      frame(vec[i].a, vec[i].b, vec[i].gap, 1'b0, -1, vec[i].e);
      cur = vec[i].e;
    end
    // Equal frame, then a 4-mismatch frame aborted at index 4: results must not move.
    cur = '{1'b1, 4'd0, 4'd0, 1'b0};
    frame(8'h3C, 8'h3C, 0, 1'b0, -1, cur);
    frame(8'h0F, 8'h00, 0, 1'b0, 4, cur);
    step();
    chk("post_abort_done", done, 0);
    // start and abort together in IDLE.
    start = 1; abort = 1;
    step();
    chk("sa_busy", busy, 0);
    start = 0; abort = 0;
    step();
    chk("sa_busy2", busy, 0);
    // start held high throughout RUN is ignored.
    cur = '{1'b0, 4'd2, 4'd1, 1'b1};
    frame(8'h06, 8'h00, 1, 1'b1, -1, cur);
    // Asynchronous reset mid-frame with non-zero results.
    cur = '{1'b0, 4'd1, 4'd7, 1'b1};
    frame(8'h80, 8'h00, 0, 1'b0, -1, cur);
    start = 1;
    step();
    start = 0; bit_valid = 1; a_bit = 1; b_bit = 0;
    repeat (3) step();
    #2 rst = 1;
    #1;
    cur = '{1'b0, 4'd0, 4'd0, 1'b0};
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk_res("arst", cur);
    bit_valid = 0;
    step();
    rst = 0;
    step();
    chk("arst_idle", busy, 0);
    m = model(8'hC3, 8'h81);
    frame(8'hC3, 8'h81, 0, 1'b0, -1, m);
    cur = m;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a, b;
      int ab;
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      m  = model(a, b);
      if (ab < 0) begin
        frame(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, m);
        cur = m;
      end else begin
        frame(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ab, cur);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_eq_checker.md
# serial_eq_checker

Bit-serial frame equality checker that consumes two serial bit streams and decides whether an entire FRAME_LEN-bit frame matched. Per-bit equality comes from the existing xnor_gate primitive; this block adds framing, a handshake, a mismatch counter and result registers. It sits directly downstream of the bit comparator and feeds control logic that needs a registered, per-frame equal/not-equal verdict.

## Interface
- FRAME_LEN, 8, number of bits per frame; legal range is 2 or more.
- CNT_W, $clog2(FRAME_LEN+1), width of the mismatch count and bit index.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a frame; accepted only in IDLE.
- abort  input  1  abandons the current frame; effective in RUN and IDLE.
- bit_valid  input  1  the a_bit/b_bit pair is presented this cycle.
- a_bit  input  1  serial stream A; frame bit index 0 arrives first.
- b_bit  input  1  serial stream B.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result outputs are updated on the same edge.
- equal  output  1  last completed frame had zero mismatches.
- mismatch_cnt  output  CNT_W  number of mismatching bits in the last completed frame, 0..FRAME_LEN.
- first_mis_idx  output  CNT_W  bit index of the first mismatch in the last completed frame.
- first_mis_valid  output  1  last completed frame had at least one mismatch.

## Operation
- States are IDLE, RUN and DONE.
  - IDLE -> RUN when start=1 and abort=0. If both are high, abort wins and the block stays in IDLE.
  - RUN: each cycle with bit_valid=1 consumes one pair.
    - eq_bit is the XNOR of a_bit and b_bit.
    - A mismatch occurs when eq_bit=0; it increments the internal accumulator.
    - The first mismatch latches the internal first index.
    - bit_idx increments on every consumed pair.
  - RUN -> DONE on the edge that consumes bit index FRAME_LEN-1.
  - RUN -> IDLE on abort=1. Abort has priority over a bit consumed in the same cycle. No done is produced.
  - DONE -> IDLE unconditionally after one cycle.
- Internal accumulators, bit_idx and the first-index latch clear on IDLE->RUN entry.
- Result outputs are updated only on the RUN->DONE edge:
  - equal = (final count == 0)
  - mismatch_cnt = final count
  - first_mis_idx and first_mis_valid are taken from the latch.
- Results hold their values until the next completed frame. Aborted frames never disturb them.
- In IDLE and DONE, bit_valid is ignored. In RUN and DONE, start is ignored.
- Counter widths: CNT_W bits, enough to hold FRAME_LEN with no overflow. bit_idx never exceeds FRAME_LEN-1.

## Timing
- On rst assertion (asynchronous):
  - state = IDLE.
  - busy, done, equal, mismatch_cnt, first_mis_idx and first_mis_valid are all 0.
  - Applies immediately, including mid-frame.
- busy rises on the edge after start is accepted and falls on the edge that enters DONE or IDLE.
- done is high for exactly the one cycle after the edge that consumes the final bit.
- Minimum frame time is FRAME_LEN+2 cycles from the start cycle to returning to IDLE. The next start can be accepted in the first IDLE cycle.
- bit_valid gaps of any length in RUN are legal and only stretch the frame.

## Configuration
- SERIAL_EQ_FIRST_IDX_EN defined: the first-mismatch latch is present and first_mis_idx/first_mis_valid behave as described above.
- SERIAL_EQ_FIRST_IDX_EN undefined: the latch is not built, and first_mis_idx and first_mis_valid are tied to 0. All other behaviour is identical.

## Structure
- Package serial_eq_pkg holds:
  - the state typedef enum {IDLE, RUN, DONE}
  - the default FRAME_LEN constant
  - a function computing CNT_W.
- Sub-module: a single xnor_gate instance producing eq_bit from a_bit and b_bit. All other logic lives in serial_eq_checker.

## Test plan
All scenarios use FRAME_LEN=8 and send index 0 first.
- Reset, start, then 8 consecutive pairs with A=B=1,0,1,0,0,1,0,1 -> done is high in cycle 10 after start, with equal=1, mismatch_cnt=0, first_mis_valid=0.
- A=all ones, B=all zeros -> equal=0, mismatch_cnt=8, first_mis_idx=0, first_mis_valid=1.
- Streams differing only at indices 5 and 7 with 3-cycle bit_valid gaps -> mismatch_cnt=2, first_mis_idx=5. done appears exactly one cycle after the 8th valid pair.
- Complete an equal frame, then start a frame with 4 mismatches and assert abort at index 4 -> busy falls next cycle, no done, and outputs still show equal=1, mismatch_cnt=0.
- Assert start and abort together in IDLE -> remains in IDLE with busy=0. Also assert start during RUN -> ignored, and the frame completes normally.
- Assert rst asynchronously at index 3 of a frame -> all outputs 0 before the next clock edge. After release, a new start is accepted normally.
